// File: rtl/gray_updown_counter.sv
// gray_updown_counter
//   Parametrised up/down Gray-code counter with parallel load, clear, and
//   wrap or saturate handling at the range ends. The Gray output is taken
//   straight from a register, so each count step changes exactly one bit.
//   This makes it safe to sample from another clock domain.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   SAT_MODE  0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   count_clr  synchronous clear (highest priority)
//   load_en    synchronous load of load_val (binary)
//   count_en   count enable; dir selects 1 = up, 0 = down
//   count      Gray-encoded value (registered)
//   count_bin  binary value (registered, same edge as count)
//   overflow   one-cycle pulse after an up-step taken at MAX
//   underflow  one-cycle pulse after a down-step taken at 0
//   at_max     registered count_bin == MAX
//   at_zero    registered count_bin == 0
module gray_updown_counter #(
  parameter int WIDTH    = 8,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_clr,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_bin,
  output logic             overflow,
  output logic             underflow,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] nxt;
  logic             ovf_nxt;
  logic             udf_nxt;

  // Next-state and flag decode; priority is clear > load > count > hold.
  always_comb begin
    nxt     = bin_q;
    ovf_nxt = 1'b0;
    udf_nxt = 1'b0;
    if (count_clr) begin
      nxt = ZERO;
    end else if (load_en) begin
      nxt = load_val;
    end else if (count_en) begin
      if (dir) begin
        if (bin_q == MAX) begin
          ovf_nxt = 1'b1;
          nxt     = SAT_MODE ? MAX : ZERO;
        end else begin
          nxt = bin_q + ONE;
        end
      end else begin
        if (bin_q == ZERO) begin
          udf_nxt = 1'b1;
          nxt     = SAT_MODE ? ZERO : MAX;
        end else begin
          nxt = bin_q - ONE;
        end
      end
    end
  end

  // Gray and binary views are loaded on the same edge from the same next value,
  // so the two outputs can never be seen disagreeing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= ZERO;
      count     <= ZERO;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      at_max    <= 1'b0;
      at_zero   <= 1'b1;
    end else begin
      bin_q     <= nxt;
      count     <= nxt ^ (nxt >> 1);
      overflow  <= ovf_nxt;
      underflow <= udf_nxt;
      at_max    <= (nxt == MAX);
      at_zero   <= (nxt == ZERO);
    end
  end

  assign count_bin = bin_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
module tb_gray_updown_counter;

  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        ld  = 1'b0;
  logic [11:0] lv  = '0;
  logic        en  = 1'b0;
  logic        dir = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // DUT outputs gathered into arrays: 0 = W8 wrap, 1 = W8 sat, 2 = W4 wrap, 3 = W12 wrap
  logic [11:0] cnt_a [ND];
  logic [11:0] bin_a [ND];
  logic        ovf_a [ND];
  logic        udf_a [ND];
  logic        amx_a [ND];
  logic        azr_a [ND];

  logic [7:0]  c0, b0, c1, b1;
  logic [3:0]  c2, b2;
  logic [11:0] c3, b3;

  gray_updown_counter #(.WIDTH(8), .SAT_MODE(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .count_clr(clr), .load_en(ld), .load_val(lv[7:0]),
    .count_en(en), .dir(dir), .count(c0), .count_bin(b0), .overflow(ovf_a[0]),
    .underflow(udf_a[0]), .at_max(amx_a[0]), .at_zero(azr_a[0]));
  gray_updown_counter #(.WIDTH(8), .SAT_MODE(1'b1)) u_w8s (
    .clk(clk), .rst(rst), .count_clr(clr), .load_en(ld), .load_val(lv[7:0]),
    .count_en(en), .dir(dir), .count(c1), .count_bin(b1), .overflow(ovf_a[1]),
    .underflow(udf_a[1]), .at_max(amx_a[1]), .at_zero(azr_a[1]));
  gray_updown_counter #(.WIDTH(4), .SAT_MODE(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .count_clr(clr), .load_en(ld), .load_val(lv[3:0]),
    .count_en(en), .dir(dir), .count(c2), .count_bin(b2), .overflow(ovf_a[2]),
    .underflow(udf_a[2]), .at_max(amx_a[2]), .at_zero(azr_a[2]));
  gray_updown_counter #(.WIDTH(12), .SAT_MODE(1'b0)) u_w12 (
    .clk(clk), .rst(rst), .count_clr(clr), .load_en(ld), .load_val(lv),
    .count_en(en), .dir(dir), .count(c3), .count_bin(b3), .overflow(ovf_a[3]),
    .underflow(udf_a[3]), .at_max(amx_a[3]), .at_zero(azr_a[3]));

  assign cnt_a[0] = {4'd0, c0};
  assign bin_a[0] = {4'd0, b0};
  assign cnt_a[1] = {4'd0, c1};
  assign bin_a[1] = {4'd0, b1};
  assign cnt_a[2] = {8'd0, c2};
  assign bin_a[2] = {8'd0, b2};
  assign cnt_a[3] = c3;
  assign bin_a[3] = b3;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: integer value plus the flags that the last edge produced.
  int wid [ND] = '{8, 8, 4, 12};
  int sat [ND] = '{0, 1, 0, 0};
  int mval [ND];
  int movf [ND];
  int mudf [ND];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < ND; i++) begin
      int top;
      top = (1 << wid[i]) - 1;
      if (rst) begin
        mval[i] <= 0; movf[i] <= 0; mudf[i] <= 0;
      end else begin
        movf[i] <= 0; mudf[i] <= 0;
        if (clr)          mval[i] <= 0;
        else if (ld)      mval[i] <= int'(lv) & top;
        else if (en && dir) begin
          if (mval[i] == top) begin
            movf[i] <= 1;
            mval[i] <= sat[i] ? top : 0;
          end else mval[i] <= mval[i] + 1;
        end else if (en) begin
          if (mval[i] == 0) begin
            mudf[i] <= 1;
            mval[i] <= sat[i] ? 0 : top;
          end else mval[i] <= mval[i] - 1;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT against the model.
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      int top;
      top = (1 << wid[i]) - 1;
      chk($sformatf("d%0d.count", i),     cnt_a[i], mval[i] ^ (mval[i] >> 1));
      chk($sformatf("d%0d.count_bin", i), bin_a[i], mval[i]);
      chk($sformatf("d%0d.overflow", i),  ovf_a[i], movf[i]);
      chk($sformatf("d%0d.underflow", i), udf_a[i], mudf[i]);
      chk($sformatf("d%0d.at_max", i),    amx_a[i], (mval[i] == top) ? 1 : 0);
      chk($sformatf("d%0d.at_zero", i),   azr_a[i], (mval[i] == 0) ? 1 : 0);
    end
  end

  // Apply one set of controls for exactly one rising edge; returns 1ns after it.
  task automatic cyc(input bit c, input bit l, input logic [11:0] v, input bit e, input bit d);
    clr = c; ld = l; lv = v; en = e; dir = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  p4;
    logic [11:0] p12;
    int          bad4, bad12;

    // Reset state
    #12;
    chk("rst.count", c0, 8'h00);
    chk("rst.at_zero", azr_a[0], 1);
    chk("rst.at_max", amx_a[0], 0);
    chk("rst.overflow", ovf_a[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Async reset in the middle of counting
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("pre_rst.count_bin", b0, 8'h03);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst.count", c0, 8'h00);
    chk("async_rst.overflow", ovf_a[0], 0);
    chk("async_rst.at_zero", azr_a[0], 1);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("hold_after_rst.count", c0, 8'h00);

    // Up count, hold, then down
    cyc(0, 0, 0, 1, 1); chk("up1.count", c0, 8'h01);
    cyc(0, 0, 0, 1, 1); chk("up2.count", c0, 8'h03);
    cyc(0, 0, 0, 1, 1); chk("up3.count", c0, 8'h02);
    cyc(0, 0, 0, 1, 1); chk("up4.count", c0, 8'h06);
    cyc(0, 0, 0, 1, 1); chk("up5.count", c0, 8'h07);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1);
    chk("hold.count", c0, 8'h07);
    cyc(0, 0, 0, 1, 0);
    chk("dn1.count_bin", b0, 8'h04); chk("dn1.count", c0, 8'h06);
    cyc(0, 0, 0, 1, 0);
    chk("dn2.count_bin", b0, 8'h03); chk("dn2.count", c0, 8'h02);
    chk("dn2.underflow", udf_a[0], 0);

    // Wrap up through MAX
    cyc(0, 1, 12'h0FE, 0, 1);
    chk("ld_fe.count", c0, 8'h81);
    cyc(0, 0, 0, 1, 1);
    chk("to_max.count", c0, 8'h80); chk("to_max.at_max", amx_a[0], 1);
    cyc(0, 0, 0, 1, 1);
    chk("wrap_up.count", c0, 8'h00); chk("wrap_up.overflow", ovf_a[0], 1);
    chk("sat_up.count", c1, 8'h80);  chk("sat_up.overflow", ovf_a[1], 1);
    cyc(0, 0, 0, 1, 1);
    chk("post_wrap.count", c0, 8'h01); chk("post_wrap.overflow", ovf_a[0], 0);

    // Wrap down through zero
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("wrap_dn.count_bin", b0, 8'hFF); chk("wrap_dn.count", c0, 8'h80);
    chk("wrap_dn.underflow", udf_a[0], 1);
    cyc(0, 0, 0, 1, 0);
    chk("post_wrap_dn.count", c0, 8'h81); chk("post_wrap_dn.underflow", udf_a[0], 0);

    // Saturate at MAX and at 0
    cyc(0, 1, 12'h0FF, 0, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 1);
      chk("sat_max.count", c1, 8'h80); chk("sat_max.overflow", ovf_a[1], 1);
    end
    cyc(0, 0, 0, 1, 0);
    chk("sat_leave_max.count_bin", b1, 8'hFE); chk("sat_leave_max.overflow", ovf_a[1], 0);
    cyc(0, 1, 12'h000, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 1, 0);
      chk("sat_zero.count", c1, 8'h00); chk("sat_zero.underflow", udf_a[1], 1);
    end
    cyc(0, 0, 0, 1, 1);
    chk("sat_leave_zero.count", c1, 8'h01); chk("sat_leave_zero.underflow", udf_a[1], 0);

    // Priority
    cyc(0, 1, 12'h033, 0, 1);
    cyc(1, 1, 12'h0AA, 1, 1);
    chk("clr_wins.count", c0, 8'h00); chk("clr_wins.overflow", ovf_a[0], 0);
    cyc(0, 1, 12'h0FF, 0, 1);
    cyc(0, 1, 12'h055, 1, 1);
    chk("load_wins.count_bin", b0, 8'h55); chk("load_wins.overflow", ovf_a[0], 0);

    // Full-range walk on the 4- and 12-bit counters: one Gray bit per step
    cyc(1, 0, 0, 0, 1);
    bad4 = 0; bad12 = 0;
    for (int k = 0; k < 4096; k++) begin
      p4 = c2; p12 = c3;
      cyc(0, 0, 0, 1, 1);
      if ($countones(p4 ^ c2) != 1)   bad4++;
      if ($countones(p12 ^ c3) != 1)  bad12++;
    end
    chk("w12.full_cycle_back_to_zero", b3, 12'h000);
    for (int k = 0; k < 20; k++) begin
      p4 = c2;
      cyc(0, 0, 0, 1, 0);
      if ($countones(p4 ^ c2) != 1) bad4++;
    end
    chk("w4.one_bit_steps", bad4, 0);
    chk("w12.one_bit_steps", bad12, 0);

    cyc(0, 0, 0, 0, 1);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
